// File: rtl/oh_pkg.sv
// Shared constants and types for the operand-handler arbiter: select codes,
// datapath widths, source ids, FSM state encoding and the shift-amount helper.
package oh_pkg;

  localparam int OH_DATA_W = 32;
  localparam int OH_IMM_W  = 21;

  localparam logic [2:0] OH_SEL_RB    = 3'b000;
  localparam logic [2:0] OH_SEL_IMM10 = 3'b001;
  localparam logic [2:0] OH_SEL_IMM13 = 3'b010;
  localparam logic [2:0] OH_SEL_UPPER = 3'b011;
  localparam logic [2:0] OH_SEL_SRL   = 3'b100;
  localparam logic [2:0] OH_SEL_SRA   = 3'b101;
  localparam logic [2:0] OH_SEL_SLL   = 3'b110;
  localparam logic [2:0] OH_SEL_ZERO  = 3'b111;

  localparam logic OH_SRC_EXE = 1'b0;
  localparam logic OH_SRC_AGU = 1'b1;

  typedef enum logic {
    OH_IDLE = 1'b0,
    OH_FULL = 1'b1
  } oh_state_e;

  // Shift distance is 31 minus the imm[9:5] field, wrapping modulo 32.
  function automatic logic [4:0] oh_shamt(input logic [OH_IMM_W-1:0] imm);
    return 5'd31 - imm[9:5];
  endfunction

endpackage

// File: rtl/oh_compute.sv
// Combinational operand function: turns (rb, imm, sel) of the granted request
// into the 32-bit operand N.
module oh_compute
  import oh_pkg::*;
(
  input  logic [OH_DATA_W-1:0] rb,
  input  logic [OH_IMM_W-1:0]  imm,
  input  logic [2:0]           sel,
  output logic [OH_DATA_W-1:0] n
);

  logic [4:0] shamt;

  assign shamt = oh_shamt(imm);

  always_comb begin
    n = '0;
    case (sel)
      OH_SEL_RB:    n = rb;
      OH_SEL_IMM10: n = {{22{imm[0]}}, imm[10:1]};
      OH_SEL_IMM13: n = {{19{imm[0]}}, imm[13:1]};
      OH_SEL_UPPER: n = {imm, 11'b0};
      OH_SEL_SRL:   n = rb >> shamt;
      OH_SEL_SRA:   n = $signed(rb) >>> shamt;
      OH_SEL_SLL:   n = rb << shamt;
      OH_SEL_ZERO:  n = '0;
      default:      n = '0;
    endcase
  end

endmodule

// File: rtl/oh_arbiter.sv
// Two-port round-robin arbiter in front of one operand datapath with a single
// registered result slot. Define OH_ARB_GRANT_CNT_EN to add per-port grant counters.
module oh_arbiter
  import oh_pkg::*;
#(
  parameter int   TAG_W   = 4,
  parameter logic RR_INIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [OH_DATA_W-1:0] req0_rb,
  input  logic [OH_IMM_W-1:0]  req0_imm,
  input  logic [2:0]           req0_sel,
  input  logic [TAG_W-1:0]     req0_tag,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [OH_DATA_W-1:0] req1_rb,
  input  logic [OH_IMM_W-1:0]  req1_imm,
  input  logic [2:0]           req1_sel,
  input  logic [TAG_W-1:0]     req1_tag,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OH_DATA_W-1:0] res_data,
  output logic [TAG_W-1:0]     res_tag,
  output logic                 res_src,
  output logic                 busy
`ifdef OH_ARB_GRANT_CNT_EN
  ,
  input  logic                 cnt_clr,
  output logic [15:0]          gnt_cnt0,
  output logic [15:0]          gnt_cnt1
`endif
);

  // Handshake: a request moves when valid && ready in the same cycle; ready is
  // combinational, never depends on that port's own payload, and is one-hot or zero.
  oh_state_e              state;
  oh_state_e              state_nxt;
  logic                   last_grant;
  logic                   armed;
  logic                   grant;
  logic                   can_accept;
  logic                   xfer0;
  logic                   xfer1;
  logic                   xfer;
  logic [OH_DATA_W-1:0]   mux_rb;
  logic [OH_IMM_W-1:0]    mux_imm;
  logic [2:0]             mux_sel;
  logic [TAG_W-1:0]       mux_tag;
  logic [OH_DATA_W-1:0]   n;

  assign res_valid = (state == OH_FULL);
  assign busy      = res_valid;

  // armed keeps both readies low while reset is held and until the first edge after release.
  assign can_accept = armed && (!res_valid || res_ready);

  always_comb begin
    grant = OH_SRC_EXE;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = OH_SRC_AGU;
    end
  end

  assign req0_ready = can_accept && (grant == OH_SRC_EXE);
  assign req1_ready = can_accept && (grant == OH_SRC_AGU);
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;
  assign xfer       = xfer0 || xfer1;

  always_comb begin
    mux_rb  = req0_rb;
    mux_imm = req0_imm;
    mux_sel = req0_sel;
    mux_tag = req0_tag;
    if (grant == OH_SRC_AGU) begin
      mux_rb  = req1_rb;
      mux_imm = req1_imm;
      mux_sel = req1_sel;
      mux_tag = req1_tag;
    end
  end

  oh_compute u_compute (
    .rb  (mux_rb),
    .imm (mux_imm),
    .sel (mux_sel),
    .n   (n)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      OH_IDLE: if (xfer) state_nxt = OH_FULL;
      OH_FULL: if (res_ready) state_nxt = xfer ? OH_FULL : OH_IDLE;
      default: state_nxt = OH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OH_IDLE;
      armed      <= 1'b0;
      last_grant <= RR_INIT;
      res_data   <= '0;
      res_tag    <= '0;
      res_src    <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (xfer) begin
        last_grant <= grant;
        res_data   <= n;
        res_tag    <= mux_tag;
        res_src    <= grant;
      end
    end
  end

`ifdef OH_ARB_GRANT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (cnt_clr) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (xfer0) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (xfer1) gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end
`endif

endmodule
